// File: rtl/rv_pipe_pkg.sv
// Shared pipeline definitions: handshake stage state encoding and
// lane indices of the EX/MEM payload map.
package rv_pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } pipe_state_e;

  localparam int unsigned EXMEM_LANES = 5;

  localparam int unsigned ALU_RESULT = 0;
  localparam int unsigned PC_JUMP    = 1;
  localparam int unsigned RD_DATA2   = 2;
  localparam int unsigned IMME       = 3;
  localparam int unsigned PC_ORDER   = 4;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter, async active-low reset.
// Ports: clk, rst_n, inc_i (count enable), cnt_o (value, holds at all-ones).
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_o <= '0;
    end else if (inc_i && (cnt_o != '1)) begin
      cnt_o <= cnt_o + W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_hs.sv
// Valid/ready pipeline stage register, LANES x DATA_W payload, sync flush,
// optional 2-entry skid buffer (SKID=1) with registered in_ready_o.
// Ports: clk, rst_n; flush_i; in_valid_i/in_ready_o/in_data_i (upstream);
//        out_valid_o/out_ready_i/out_data_o (downstream); stall_cnt_o.
module pipe_stage_hs
  import rv_pipe_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LANES  = 5,
  parameter int unsigned SKID   = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [LANES*DATA_W-1:0] in_data_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [LANES*DATA_W-1:0] out_data_o,
  output logic [CNT_W-1:0]        stall_cnt_o
);

  localparam int unsigned PW = LANES * DATA_W;

  logic stall;
  assign stall = out_valid_o & ~out_ready_i;

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc_i(stall),
    .cnt_o(stall_cnt_o)
  );

  if (SKID != 0) begin : g_skid

    pipe_state_e   state_q;
    pipe_state_e   state_d;
    logic [PW-1:0] head_q;
    logic [PW-1:0] skid_q;
    logic          rdy_q;
    logic          xin;
    logic          xout;
    logic          ld_head;
    logic          ld_skid;
    logic          pop_skid;

    assign xin  = in_valid_i & rdy_q;
    assign xout = (state_q != ST_EMPTY) & out_ready_i;

    always_comb begin
      state_d  = state_q;
      ld_head  = 1'b0;
      ld_skid  = 1'b0;
      pop_skid = 1'b0;
      unique case (state_q)
        ST_EMPTY: begin
          if (xin) begin
            state_d = ST_ONE;
            ld_head = 1'b1;
          end
        end
        ST_ONE: begin
          if (xin && xout) begin
            ld_head = 1'b1;
          end else if (xin) begin
            state_d = ST_TWO;
            ld_skid = 1'b1;
          end else if (xout) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (xout) begin
            state_d  = ST_ONE;
            pop_skid = 1'b1;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
      // Flush overrides everything, including an accepted input.
      if (flush_i) begin
        state_d  = ST_EMPTY;
        ld_head  = 1'b0;
        ld_skid  = 1'b0;
        pop_skid = 1'b0;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= ST_EMPTY;
        rdy_q   <= 1'b1;
      end else begin
        state_q <= state_d;
        rdy_q   <= (state_d != ST_TWO);
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        head_q <= '0;
      end else if (ld_head) begin
        head_q <= in_data_i;
      end else if (pop_skid) begin
        head_q <= skid_q;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        skid_q <= '0;
      end else if (ld_skid) begin
        skid_q <= in_data_i;
      end
    end

    assign in_ready_o  = rdy_q;
    assign out_valid_o = (state_q != ST_EMPTY);
    assign out_data_o  = head_q;

    a_no_in_two : assert property (
      @(posedge clk) disable iff (!rst_n)
      !((state_q == ST_TWO) && xin));

    a_stable : assert property (
      @(posedge clk) disable iff (!rst_n)
      (out_valid_o && !out_ready_i && !flush_i)
      |=> (out_valid_o && $stable(out_data_o)));

  end else begin : g_single

    logic          valid_q;
    logic [PW-1:0] head_q;
    logic          xin;

    assign in_ready_o = ~valid_q | out_ready_i;
    assign xin        = in_valid_i & in_ready_o;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
      end else if (flush_i) begin
        valid_q <= 1'b0;
      end else if (xin) begin
        valid_q <= 1'b1;
      end else if (out_ready_i) begin
        valid_q <= 1'b0;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        head_q <= '0;
      end else if (xin && !flush_i) begin
        head_q <= in_data_i;
      end
    end

    assign out_valid_o = valid_q;
    assign out_data_o  = head_q;

  end

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Bench for pipe_stage_hs: SKID=0 (u0) and SKID=1 (u1) side by side,
// directed vector table, stall/flush/reset sequences, random scoreboard.
module tb_pipe_stage_hs;

  localparam int DW = 32;
  localparam int LN = 5;
  localparam int CW = 4;
  localparam int PW = DW * LN;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          iv    = 1'b0;
  logic          ordy  = 1'b0;
  logic [PW-1:0] idata = '0;

  logic          rdy0, rdy1, ov0, ov1;
  logic [PW-1:0] od0, od1;
  logic [CW-1:0] cnt0, cnt1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_stage_hs #(
    .DATA_W(DW), .LANES(LN), .SKID(0), .CNT_W(CW)
  ) u0 (
    .clk(clk), .rst_n(rst_n), .flush_i(flush),
    .in_valid_i(iv), .in_ready_o(rdy0), .in_data_i(idata),
    .out_valid_o(ov0), .out_ready_i(ordy), .out_data_o(od0),
    .stall_cnt_o(cnt0)
  );

  pipe_stage_hs #(
    .DATA_W(DW), .LANES(LN), .SKID(1), .CNT_W(CW)
  ) u1 (
    .clk(clk), .rst_n(rst_n), .flush_i(flush),
    .in_valid_i(iv), .in_ready_o(rdy1), .in_data_i(idata),
    .out_valid_o(ov1), .out_ready_i(ordy), .out_data_o(od1),
    .stall_cnt_o(cnt1)
  );

  function automatic logic [PW-1:0] mk(input logic [23:0] v);
    logic [PW-1:0] r;
    r = '0;
    for (int k = 0; k < LN; k++) r[k*DW +: DW] = {8'(k), v};
    return r;
  endfunction

  task automatic chk(input string nm, input logic [PW-1:0] act,
                     input logic [PW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        fl;
    logic        iv;
    logic [23:0] d;
    logic        ordy;
    logic        v0;
    logic [23:0] e0;
    logic        r0;
    logic        v1;
    logic [23:0] e1;
    logic        r1;
    logic [3:0]  c;
  } vec_t;

  vec_t tbl [17];

  logic [PW-1:0] q0[$];
  logic [PW-1:0] q1[$];

  initial begin
    int n0, n1, cyc, seq;
    logic st0, st1;
    logic [PW-1:0] h0, h1;
    logic [3:0] ec;

    // fl iv d ordy | v0 e0 r0 | v1 e1 r1 | cnt
    tbl[0]  = '{0,1,24'h1,1, 0,24'h0,1, 0,24'h0,1, 4'd0};
    tbl[1]  = '{0,1,24'h2,1, 1,24'h1,1, 1,24'h1,1, 4'd0};
    tbl[2]  = '{0,1,24'h3,1, 1,24'h2,1, 1,24'h2,1, 4'd0};
    tbl[3]  = '{0,0,24'h0,1, 1,24'h3,1, 1,24'h3,1, 4'd0};
    tbl[4]  = '{0,0,24'h0,0, 0,24'h0,1, 0,24'h0,1, 4'd0};
    tbl[5]  = '{0,1,24'hA,0, 0,24'h0,1, 0,24'h0,1, 4'd0};
    tbl[6]  = '{0,1,24'hB,0, 1,24'hA,0, 1,24'hA,1, 4'd0};
    tbl[7]  = '{0,0,24'h0,0, 1,24'hA,0, 1,24'hA,0, 4'd1};
    tbl[8]  = '{0,1,24'hB,1, 1,24'hA,1, 1,24'hA,0, 4'd2};
    tbl[9]  = '{0,0,24'h0,1, 1,24'hB,1, 1,24'hB,1, 4'd2};
    tbl[10] = '{0,0,24'h0,1, 0,24'h0,1, 0,24'h0,1, 4'd2};
    tbl[11] = '{0,1,24'hA,0, 0,24'h0,1, 0,24'h0,1, 4'd2};
    tbl[12] = '{0,1,24'hB,0, 1,24'hA,0, 1,24'hA,1, 4'd2};
    tbl[13] = '{1,1,24'hC,0, 1,24'hA,0, 1,24'hA,0, 4'd3};
    tbl[14] = '{1,1,24'hD,1, 0,24'h0,1, 0,24'h0,1, 4'd4};
    tbl[15] = '{0,0,24'h0,1, 0,24'h0,1, 0,24'h0,1, 4'd4};
    tbl[16] = '{0,0,24'h0,0, 0,24'h0,1, 0,24'h0,1, 4'd4};

    // Power-on reset state
    #12;
    chk("rst u0 valid", PW'(ov0), PW'(0));
    chk("rst u1 valid", PW'(ov1), PW'(0));
    chk("rst u0 data", od0, '0);
    chk("rst u1 data", od1, '0);
    chk("rst u0 cnt", PW'(cnt0), PW'(0));
    chk("rst u1 cnt", PW'(cnt1), PW'(0));
    chk("rst u1 ready", PW'(rdy1), PW'(1));
    chk("rst u0 ready", PW'(rdy0), PW'(1));
    rst_n = 1'b1;
    step();

    // Directed table: streaming, backpressure, flush
    for (int i = 0; i < 17; i++) begin
      flush = tbl[i].fl;
      iv    = tbl[i].iv;
      idata = mk(tbl[i].d);
      ordy  = tbl[i].ordy;
      #1;
      chk($sformatf("vec%0d u0 valid", i), PW'(ov0), PW'(tbl[i].v0));
      chk($sformatf("vec%0d u1 valid", i), PW'(ov1), PW'(tbl[i].v1));
      chk($sformatf("vec%0d u0 ready", i), PW'(rdy0), PW'(tbl[i].r0));
      chk($sformatf("vec%0d u1 ready", i), PW'(rdy1), PW'(tbl[i].r1));
      chk($sformatf("vec%0d u0 cnt", i), PW'(cnt0), PW'(tbl[i].c));
      chk($sformatf("vec%0d u1 cnt", i), PW'(cnt1), PW'(tbl[i].c));
      if (tbl[i].v0) chk($sformatf("vec%0d u0 data", i), od0, mk(tbl[i].e0));
      if (tbl[i].v1) chk($sformatf("vec%0d u1 data", i), od1, mk(tbl[i].e1));
      step();
    end

    // Stall counter saturation, flush does not clear it
    flush = 1'b0;
    iv    = 1'b1;
    idata = mk(24'h55);
    ordy  = 1'b0;
    step();
    iv = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      step();
      ec = (4 + i > 15) ? 4'd15 : 4'(4 + i);
      chk($sformatf("sat%0d u0 cnt", i), PW'(cnt0), PW'(ec));
      chk($sformatf("sat%0d u1 cnt", i), PW'(cnt1), PW'(ec));
      chk($sformatf("sat%0d u0 data", i), od0, mk(24'h55));
      chk($sformatf("sat%0d u1 data", i), od1, mk(24'h55));
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush u0 cnt", PW'(cnt0), PW'(15));
    chk("flush u1 cnt", PW'(cnt1), PW'(15));
    chk("flush u0 valid", PW'(ov0), PW'(0));
    chk("flush u1 valid", PW'(ov1), PW'(0));
    chk("flush u1 ready", PW'(rdy1), PW'(1));

    // Asynchronous reset mid-stream
    iv    = 1'b1;
    idata = mk(24'h77);
    ordy  = 1'b0;
    step();
    iv = 1'b0;
    chk("pre-rst u0 valid", PW'(ov0), PW'(1));
    chk("pre-rst u1 valid", PW'(ov1), PW'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid-rst u0 valid", PW'(ov0), PW'(0));
    chk("mid-rst u1 valid", PW'(ov1), PW'(0));
    chk("mid-rst u0 data", od0, '0);
    chk("mid-rst u1 data", od1, '0);
    chk("mid-rst u0 cnt", PW'(cnt0), PW'(0));
    chk("mid-rst u1 cnt", PW'(cnt1), PW'(0));
    chk("mid-rst u1 ready", PW'(rdy1), PW'(1));
    #1;
    rst_n = 1'b1;
    step();

    // Random valid/ready with scoreboards
    n0 = 0; n1 = 0; cyc = 0; seq = 0;
    st0 = 1'b0; st1 = 1'b0; h0 = '0; h1 = '0;
    while ((n0 < 10000 || n1 < 10000) && cyc < 60000) begin
      iv    = 1'($urandom_range(0, 1));
      ordy  = 1'($urandom_range(0, 1));
      idata = mk(24'(seq));
      idata[DW +: DW] = $urandom;
      seq++;
      #1;
      if (st0) begin
        chk("rnd u0 stall data", od0, h0);
        chk("rnd u0 stall valid", PW'(ov0), PW'(1));
      end
      if (st1) begin
        chk("rnd u1 stall data", od1, h1);
        chk("rnd u1 stall valid", PW'(ov1), PW'(1));
      end
      if (ov0 && ordy) begin
        if (q0.size() == 0) chk("rnd u0 extra", od0, ~od0);
        else chk("rnd u0 order", od0, q0.pop_front());
        n0++;
      end
      if (ov1 && ordy) begin
        if (q1.size() == 0) chk("rnd u1 extra", od1, ~od1);
        else chk("rnd u1 order", od1, q1.pop_front());
        n1++;
      end
      if (iv && rdy0) q0.push_back(idata);
      if (iv && rdy1) q1.push_back(idata);
      st0 = ov0 && !ordy;
      st1 = ov1 && !ordy;
      h0 = od0;
      h1 = od1;
      step();
      cyc++;
    end
    if (n0 < 10000 || n1 < 10000) begin
      errors++;
      $display("FAIL rnd timeout: got %0d/%0d transfers required 10000",
               n0, n1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
